// File: rtl/ux607_tl_frag_a_splitter.sv
// TL-A fragment splitter for the 8-bit peripheral path.
// Breaks each 2^size-byte A request into single-byte fragments. For Get/Hint
// it asks the upstream repeater to replay the header once per fragment. Put and
// Atomic data beats pass through one-for-one and are relabelled as size 0.
module ux607_tl_frag_a_splitter #(
  parameter int unsigned MAX_SIZE_LOG2 = 6
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_in_ready,
  input  logic        io_in_valid,
  input  logic [2:0]  io_in_bits_opcode,
  input  logic [2:0]  io_in_bits_param,
  input  logic [2:0]  io_in_bits_size,
  input  logic [1:0]  io_in_bits_source,
  input  logic [29:0] io_in_bits_address,
  input  logic        io_in_bits_mask,
  input  logic [7:0]  io_in_bits_data,
  output logic        io_repeat,
  input  logic        io_out_ready,
  output logic        io_out_valid,
  output logic [2:0]  io_out_bits_opcode,
  output logic [2:0]  io_out_bits_param,
  output logic [2:0]  io_out_bits_size,
  output logic [1:0]  io_out_bits_source,
  output logic [29:0] io_out_bits_address,
  output logic        io_out_bits_mask,
  output logic [7:0]  io_out_bits_data,
  output logic        io_out_first,
  output logic        io_out_last,
  output logic        io_oversize
);

  logic [MAX_SIZE_LOG2-1:0] r_cnt;
  logic                     r_oversize;

  logic [2:0]               w_eff_size;
  logic [MAX_SIZE_LOG2-1:0] w_beat_mask;
  logic                     w_repeat_class;
  logic                     w_illegal;
  logic                     w_too_big;
  logic                     w_last;
  logic                     w_fire;

  // Classify the request and derive the last-fragment condition.
  always_comb begin
    w_repeat_class = (io_in_bits_opcode == 3'd4) || (io_in_bits_opcode == 3'd5);
    w_illegal      = (io_in_bits_opcode == 3'd6) || (io_in_bits_opcode == 3'd7);
    w_too_big      = (32'(io_in_bits_size) > MAX_SIZE_LOG2);
    w_eff_size     = w_too_big ? 3'(MAX_SIZE_LOG2) : io_in_bits_size;
    // beats-1 as a mask of the low eff_size bits
    for (int i = 0; i < int'(MAX_SIZE_LOG2); i++) begin
      w_beat_mask[i] = (i < int'(w_eff_size));
    end
    if (w_illegal || (w_eff_size == 3'd0)) begin
      w_last = 1'b1;
    end else begin
      w_last = (r_cnt == w_beat_mask);
    end
    w_fire = io_in_valid & io_out_ready;
  end

  // Fragment counter and sticky oversize flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_oversize <= 1'b0;
    end else if (w_fire && !w_illegal) begin
      r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
      r_oversize <= r_oversize | w_too_big;
    end
  end

  // Fragment outputs; illegal opcodes are forwarded untouched as one beat.
  always_comb begin
    io_out_valid        = io_in_valid;
    io_in_ready         = io_out_ready;
    io_repeat           = io_in_valid & w_repeat_class & ~w_last;
    io_out_bits_opcode  = io_in_bits_opcode;
    io_out_bits_param   = io_in_bits_param;
    io_out_bits_source  = io_in_bits_source;
    io_out_bits_data    = io_in_bits_data;
    io_out_first        = (r_cnt == '0);
    io_out_last         = w_last;
    io_oversize         = r_oversize;
    io_out_bits_address = io_in_bits_address;
    io_out_bits_size    = io_in_bits_size;
    io_out_bits_mask    = io_in_bits_mask;
    if (!w_illegal) begin
      io_out_bits_address = io_in_bits_address | 30'(r_cnt);
      io_out_bits_size    = (w_eff_size != 3'd0) ? 3'd0 : io_in_bits_size;
      io_out_bits_mask    = w_repeat_class ? 1'b1 : io_in_bits_mask;
    end
  end

endmodule

// File: tb/tb_ux607_tl_frag_a_splitter.sv
// Directed bench for the TL-A fragment splitter; the bench plays the repeater.
module tb_ux607_tl_frag_a_splitter;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_ready;
  logic        io_in_valid;
  logic [2:0]  io_in_bits_opcode;
  logic [2:0]  io_in_bits_param;
  logic [2:0]  io_in_bits_size;
  logic [1:0]  io_in_bits_source;
  logic [29:0] io_in_bits_address;
  logic        io_in_bits_mask;
  logic [7:0]  io_in_bits_data;
  logic        io_repeat;
  logic        io_out_ready;
  logic        io_out_valid;
  logic [2:0]  io_out_bits_opcode;
  logic [2:0]  io_out_bits_param;
  logic [2:0]  io_out_bits_size;
  logic [1:0]  io_out_bits_source;
  logic [29:0] io_out_bits_address;
  logic        io_out_bits_mask;
  logic [7:0]  io_out_bits_data;
  logic        io_out_first;
  logic        io_out_last;
  logic        io_oversize;

  int n_pass  = 0;
  int n_total = 0;

  // {address, size, mask, repeat, first, last}
  logic [36:0] obs;
  logic [36:0] exp_v;
  assign obs = {io_out_bits_address, io_out_bits_size, io_out_bits_mask,
                io_repeat, io_out_first, io_out_last};

  ux607_tl_frag_a_splitter #(.MAX_SIZE_LOG2(6)) dut (
    .clock               (clock),
    .reset               (reset),
    .io_in_ready         (io_in_ready),
    .io_in_valid         (io_in_valid),
    .io_in_bits_opcode   (io_in_bits_opcode),
    .io_in_bits_param    (io_in_bits_param),
    .io_in_bits_size     (io_in_bits_size),
    .io_in_bits_source   (io_in_bits_source),
    .io_in_bits_address  (io_in_bits_address),
    .io_in_bits_mask     (io_in_bits_mask),
    .io_in_bits_data     (io_in_bits_data),
    .io_repeat           (io_repeat),
    .io_out_ready        (io_out_ready),
    .io_out_valid        (io_out_valid),
    .io_out_bits_opcode  (io_out_bits_opcode),
    .io_out_bits_param   (io_out_bits_param),
    .io_out_bits_size    (io_out_bits_size),
    .io_out_bits_source  (io_out_bits_source),
    .io_out_bits_address (io_out_bits_address),
    .io_out_bits_mask    (io_out_bits_mask),
    .io_out_bits_data    (io_out_bits_data),
    .io_out_first        (io_out_first),
    .io_out_last         (io_out_last),
    .io_oversize         (io_oversize)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [29:0] addr, input logic m, input logic [7:0] d);
    io_in_valid        = v;
    io_in_bits_opcode  = op;
    io_in_bits_param   = 3'd2;
    io_in_bits_size    = sz;
    io_in_bits_source  = 2'd1;
    io_in_bits_address = addr;
    io_in_bits_mask    = m;
    io_in_bits_data    = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_out_ready = 1'b0;
    drive(1'b0, 3'd4, 3'd0, 30'h0, 1'b0, 8'h00);
    #3;
    n_total++;
    if ({io_out_valid, io_in_ready, io_repeat, io_oversize, io_out_first} !== 5'b00001)
      $display("FAIL reset_state got=%b want=00001",
               {io_out_valid, io_in_ready, io_repeat, io_oversize, io_out_first});
    else n_pass++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_get4();
    io_out_ready = 1'b1;
    drive(1'b1, 3'd4, 3'd2, 30'h100, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_v = {30'h100 + 30'(i), 3'd0, 1'b1, i < 3, i == 0, i == 3};
      n_total++;
      if (obs !== exp_v) $display("FAIL get4_beat%0d got=%h want=%h", i, obs, exp_v);
      else n_pass++;
      step();
    end
    drive(1'b0, 3'd4, 3'd0, 30'h0, 1'b0, 8'h00);
  endtask

  task automatic test_put2();
    logic [7:0] dat [2];
    dat[0] = 8'hA5;
    dat[1] = 8'h5A;
    io_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd0, 3'd1, 30'h20, 1'b1, dat[i]);
      #1;
      n_total++;
      if ({io_out_valid, io_in_ready, io_out_bits_opcode, io_out_bits_param,
           io_out_bits_source, io_out_bits_data, obs} !==
          {1'b1, 1'b1, 3'd0, 3'd2, 2'd1, dat[i],
           30'h20 + 30'(i), 3'd0, 1'b1, 1'b0, i == 0, i == 1})
        $display("FAIL put2_beat%0d got addr=%h data=%h rep=%b last=%b want addr=%h data=%h",
                 i, io_out_bits_address, io_out_bits_data, io_repeat, io_out_last,
                 30'h20 + 30'(i), dat[i]);
      else n_pass++;
      step();
    end
    drive(1'b0, 3'd0, 3'd0, 30'h0, 1'b0, 8'h00);
    #1;
    n_total++;
    if (io_out_first !== 1'b1) $display("FAIL put2_cnt_zero got first=%b want=1", io_out_first);
    else n_pass++;
  endtask

  task automatic test_stall();
    int fires = 0;
    drive(1'b1, 3'd4, 3'd3, 30'h200, 1'b1, 8'h00);
    for (int cyc = 0; cyc < 40 && fires < 8; cyc++) begin
      io_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      exp_v = {30'h200 + 30'(fires), 3'd0, 1'b1, fires < 7, fires == 0, fires == 7};
      n_total++;
      if (obs !== exp_v) $display("FAIL stall_cyc%0d got=%h want=%h", cyc, obs, exp_v);
      else n_pass++;
      if (io_out_ready) fires++;
      step();
    end
    drive(1'b0, 3'd4, 3'd0, 30'h0, 1'b0, 8'h00);
    io_out_ready = 1'b1;
    #1;
    n_total++;
    if ({fires, io_out_first} !== {32'd8, 1'b1})
      $display("FAIL stall_fires got fires=%0d first=%b want fires=8 first=1", fires, io_out_first);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    io_out_ready = 1'b1;
    drive(1'b1, 3'd4, 3'd0, 30'h300, 1'b1, 8'h00);
    #1;
    exp_v = {30'h300, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    n_total++;
    if (obs !== exp_v) $display("FAIL b2b_size0 got=%h want=%h", obs, exp_v);
    else n_pass++;
    step();
    drive(1'b1, 3'd4, 3'd1, 30'h310, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_v = {30'h310 + 30'(i), 3'd0, 1'b1, i == 0, i == 0, i == 1};
      n_total++;
      if (obs !== exp_v) $display("FAIL b2b_size1_beat%0d got=%h want=%h", i, obs, exp_v);
      else n_pass++;
      step();
    end
    drive(1'b0, 3'd4, 3'd0, 30'h0, 1'b0, 8'h00);
  endtask

  task automatic test_illegal();
    io_out_ready = 1'b1;
    drive(1'b1, 3'd6, 3'd2, 30'h503, 1'b0, 8'h33);
    #1;
    exp_v = {30'h503, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    n_total++;
    if (obs !== exp_v) $display("FAIL illegal_fwd got=%h want=%h", obs, exp_v);
    else n_pass++;
    step();
    drive(1'b0, 3'd4, 3'd0, 30'h0, 1'b0, 8'h00);
    #1;
    n_total++;
    if (io_out_first !== 1'b1) $display("FAIL illegal_cnt got first=%b want=1", io_out_first);
    else n_pass++;
  endtask

  task automatic test_oversize();
    int errs = 0;
    io_out_ready = 1'b1;
    drive(1'b1, 3'd4, 3'd7, 30'h1000, 1'b1, 8'h00);
    #1;
    n_total++;
    if (io_oversize !== 1'b0) $display("FAIL oversize_pre got=%b want=0", io_oversize);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      exp_v = {30'h1000 + 30'(i), 3'd0, 1'b1, i < 63, i == 0, i == 63};
      if (obs !== exp_v) begin
        if (errs == 0) $display("FAIL oversize_beat%0d got=%h want=%h", i, obs, exp_v);
        errs++;
      end
      step();
      if (i == 0) begin
        n_total++;
        if (io_oversize !== 1'b1) $display("FAIL oversize_rise got=%b want=1", io_oversize);
        else n_pass++;
      end
    end
    n_total++;
    if (errs != 0) $display("FAIL oversize_beats got errors=%0d want 0", errs);
    else n_pass++;
    drive(1'b0, 3'd4, 3'd0, 30'h0, 1'b0, 8'h00);
    #1;
    n_total++;
    if ({io_oversize, io_out_first} !== 2'b11)
      $display("FAIL oversize_sticky got=%b want=11", {io_oversize, io_out_first});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    io_out_ready = 1'b1;
    drive(1'b1, 3'd4, 3'd3, 30'h400, 1'b1, 8'h00);
    step();
    step();
    #1;
    n_total++;
    if (io_out_bits_address !== 30'h402)
      $display("FAIL rstmid_pre got addr=%h want=402", io_out_bits_address);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({io_out_first, io_oversize, io_out_bits_address} !== {1'b1, 1'b0, 30'h400})
      $display("FAIL rstmid_clear got first=%b ovs=%b addr=%h want 1 0 400",
               io_out_first, io_oversize, io_out_bits_address);
    else n_pass++;
    drive(1'b0, 3'd4, 3'd0, 30'h0, 1'b0, 8'h00);
    step();
    reset = 1'b0;
    step();
    drive(1'b1, 3'd4, 3'd1, 30'h40, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_v = {30'h40 + 30'(i), 3'd0, 1'b1, i == 0, i == 0, i == 1};
      n_total++;
      if (obs !== exp_v) $display("FAIL rstmid_get_beat%0d got=%h want=%h", i, obs, exp_v);
      else n_pass++;
      step();
    end
    drive(1'b0, 3'd4, 3'd0, 30'h0, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_get4();
    test_put2();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_oversize();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
